// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-divider bank: NUM_CH divided square waves
// with rising-edge tick enables, glitch-free re-configuration and global resync.

module clk_div_ch #(
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = 1,
  parameter bit INIT_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdiv,
  input  logic [DIV_W-1:0] wphase,
  output logic             clk_out,
  output logic             tick,
  output logic             commit
);
  logic [DIV_W-1:0] div_q, phase_q, pdiv_q, pphase_q, cnt_q;
  logic             pend_q, en_q;
  logic             load, wrap, take_wr, take_pend;
  logic [DIV_W-1:0] cur_e, div_n, phase_n, div_e, ph_e;

  always_comb begin
    cur_e     = (div_q == '0) ? DIV_W'(1) : div_q;
    // enable rising edge behaves exactly like a sync for this lane
    load      = en && (sync || !en_q);
    wrap      = en && !load && (cnt_q >= cur_e - DIV_W'(1));
    take_wr   = load && wr;
    take_pend = pend_q && !take_wr && (!en || load || wrap);
    commit    = take_wr || take_pend;
    div_n     = take_wr ? wdiv   : (take_pend ? pdiv_q   : div_q);
    phase_n   = take_wr ? wphase : (take_pend ? pphase_q : phase_q);
    div_e     = (div_n == '0) ? DIV_W'(1) : div_n;
    ph_e      = (phase_n >= div_e) ? div_e - DIV_W'(1) : phase_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_W'(DEF_DIV);
      phase_q  <= '0;
      pdiv_q   <= '0;
      pphase_q <= '0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      clk_out  <= INIT_LVL;
      tick     <= 1'b0;
    end else begin
      div_q   <= div_n;
      phase_q <= phase_n;
      en_q    <= en;
      if (commit) pend_q <= 1'b0;
      // a write not consumed by a load lands in pending (overwriting any older one)
      if (wr && !take_wr) begin
        pend_q   <= 1'b1;
        pdiv_q   <= wdiv;
        pphase_q <= wphase;
      end
      if (!en) begin
        cnt_q   <= '0;
        clk_out <= INIT_LVL;
        tick    <= 1'b0;
      end else if (load) begin
        cnt_q   <= ph_e;
        clk_out <= INIT_LVL;
        tick    <= 1'b0;
      end else if (wrap) begin
        cnt_q   <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt_q   <= cnt_q + DIV_W'(1);
        tick    <= 1'b0;
      end
    end
  end
endmodule

module clk_div_bank #(
  parameter  int NUM_CH   = 6,
  parameter  int DIV_W    = 16,
  parameter  int DEF_DIV  = 1,
  parameter  bit INIT_LVL = 1'b1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              sync_start,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_ack
);
  logic [NUM_CH-1:0] hit, commit;

  // out-of-range cfg_ch matches no lane, so such writes vanish silently
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i] = cfg_we && (cfg_ch == CH_W'(i));
    clk_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV),
      .INIT_LVL(INIT_LVL)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (ch_en[i]),
      .sync   (sync_start),
      .wr     (hit[i]),
      .wdiv   (cfg_div),
      .wphase (cfg_phase),
      .clk_out(clk_out[i]),
      .tick   (tick[i]),
      .commit (commit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_ack <= 1'b0;
    else     cfg_ack <= |commit;
  end
endmodule
